// File: rtl/byte_field_seq_pkg.sv
// Shared encodings for the byte-field sequencer: op codes, FSM states and
// the field-wrap predicate used when building the mask.
package byte_field_seq_pkg;

  localparam int DATA_W = 32;
  localparam int FLD_W  = 5;

  typedef enum logic [1:0] {
    OP_LDB = 2'b00,
    OP_DPB = 2'b01,
    OP_SDP = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOOKUP = 2'b01,
    MERGE  = 2'b10,
    DONE   = 2'b11
  } state_e;

  // A field whose top bit lands past bit 31 wraps around to the low end.
  function automatic logic field_wraps(input logic [FLD_W-1:0] pos,
                                       input logic [FLD_W-1:0] wm1);
    logic [FLD_W:0] sum;
    sum = {1'b0, pos} + {1'b0, wm1};
    return sum[FLD_W];
  endfunction

endpackage

// File: rtl/mask_prom.sv
// Registered 32x32 mask PROMs: left PROM sets bits [addr:0], right PROM
// sets bits [31:addr]. Contents are constant; only the read is clocked.
module lmask_prom
  import byte_field_seq_pkg::*;
(
  input  logic              clk,
  input  logic [FLD_W-1:0]  addr,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    q <= {DATA_W{1'b1}} >> (5'd31 - addr);
  end

endmodule

module rmask_prom
  import byte_field_seq_pkg::*;
(
  input  logic              clk,
  input  logic [FLD_W-1:0]  addr,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    q <= {DATA_W{1'b1}} << addr;
  end

endmodule

// File: rtl/rot32.sv
// Combinational 32-bit rotator; left=1 rotates toward the MSB.
module rot32
  import byte_field_seq_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [FLD_W-1:0]  amt,
  input  logic              left,
  output logic [DATA_W-1:0] res
);

  logic [FLD_W-1:0] idx;

  always_comb begin
    res = '0;
    idx = '0;
    for (int i = 0; i < DATA_W; i++) begin
      idx    = left ? (FLD_W'(i) - amt) : (FLD_W'(i) + amt);
      res[i] = data[idx];
    end
  end

endmodule

// File: rtl/byte_field_seq.sv
// Byte-field sequencer: LDB / DPB / selective deposit on a 32-bit word,
// built from two mask PROM lookups and one shared rotator.
module byte_field_seq
  import byte_field_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_pos,
  input  logic [4:0]  req_wm1,
  input  logic [31:0] req_a,
  input  logic [31:0] req_m,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  state_e state, state_nxt;
  logic   accept;

  logic [FLD_W-1:0]  lm_addr, rm_addr;
  logic [DATA_W-1:0] lmask, rmask, rot_m, merge_val;

  op_e               op_p0;
  logic [FLD_W-1:0]  pos_p0, wm1_p0;
  logic [DATA_W-1:0] a_p0, m_p0;
  logic [DATA_W-1:0] mask_p1;
  logic [DATA_W-1:0] data_p2;
  logic              err_p2;

  assign accept = req_valid & req_ready;

  always_comb begin
    lm_addr = (req_op == OP_LDB) ? req_wm1 : (req_pos + req_wm1);
    rm_addr = (req_op == OP_LDB) ? 5'd0 : req_pos;
  end

  lmask_prom u_lmask (.clk(clk), .addr(lm_addr), .q(lmask));
  rmask_prom u_rmask (.clk(clk), .addr(rm_addr), .q(rmask));

  rot32 u_rot (
    .data (m_p0),
    .amt  (pos_p0),
    .left (op_p0 != OP_LDB),
    .res  (rot_m)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = LOOKUP;
      LOOKUP:                  state_nxt = MERGE;
      MERGE:                   state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
  end

  // p0: operand capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= op_e'(req_op);
      pos_p0 <= req_pos;
      wm1_p0 <= req_wm1;
      a_p0   <= req_a;
      m_p0   <= req_m;
    end
  end

  // p1: mask from PROM outputs; a wrapped field is the union of both ends
  always_ff @(posedge clk) begin
    if (state == LOOKUP) begin
      if (op_p0 != OP_LDB && field_wraps(pos_p0, wm1_p0)) mask_p1 <= lmask | rmask;
      else                                                mask_p1 <= lmask & rmask;
    end
  end

  always_comb begin
    case (op_p0)
      OP_LDB:  merge_val = rot_m & mask_p1;
      OP_DPB:  merge_val = (a_p0 & ~mask_p1) | (rot_m & mask_p1);
      OP_SDP:  merge_val = (a_p0 & ~mask_p1) | (m_p0 & mask_p1);
      default: merge_val = a_p0;
    endcase
  end

  // p2: result register, cleared by reset so the idle response reads zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_p2 <= '0;
      err_p2  <= 1'b0;
    end else if (state == MERGE) begin
      data_p2 <= merge_val;
      err_p2  <= (op_p0 == OP_RSV);
    end
  end

  assign resp_data = data_p2;
  assign resp_err  = err_p2;

endmodule

// File: tb/tb_byte_field_seq.sv
// Scoreboard bench for byte_field_seq: directed requests push expected
// results; a negedge monitor pops and compares on each response handshake.
module tb_byte_field_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_pos;
  logic [4:0]  req_wm1;
  logic [31:0] req_a;
  logic [31:0] req_m;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   since = 0;
  int   last_acc = 0;
  int   resp_cnt = 0;
  bit   tracking = 0;
  bit   gap_chk = 0;
  logic prev_rv = 1'b0;

  byte_field_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_pos    (req_pos),
    .req_wm1    (req_wm1),
    .req_a      (req_a),
    .req_m      (req_m),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: latency from accept, request spacing, and scoreboard pops.
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (req_valid && req_ready) begin
        if (gap_chk) begin
          chk("req_spacing", 32'(cyc - last_acc), 32'd4);
          gap_chk = 0;
        end
        last_acc = cyc;
        since    = 0;
        tracking = 1;
      end else if (tracking) begin
        since++;
      end
      if (resp_valid && !prev_rv && tracking) begin
        chk("latency", 32'(since), 32'd3);
        tracking = 0;
      end
      if (resp_valid && resp_ready) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got %h with nothing expected", resp_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end
    prev_rv = resp_valid;
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] pos, input logic [4:0] wm1,
                       input logic [31:0] a, input logic [31:0] m,
                       input logic [31:0] d, input logic e, input bit push);
    int n;
    exp_t x;
    if (push) begin
      x.data = d;
      x.err  = e;
      exp_q.push_back(x);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_pos   = pos;
    req_wm1   = wm1;
    req_a     = a;
    req_m     = m;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || !req_ready) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt_before;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_pos    = 5'd0;
    req_wm1    = 5'd0;
    req_a      = 32'h0;
    req_m      = 32'h0;
    resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err",   32'(resp_err),   32'd0);
    chk("rst_resp_data",  resp_data,       32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready",  32'(req_ready),  32'd1);

    issue(2'b00, 5'd8,  5'd7,  32'h0,        32'h12345678, 32'h00000056, 1'b0, 1); drain();
    issue(2'b01, 5'd4,  5'd3,  32'hFFFFFFFF, 32'h00000005, 32'hFFFFFF5F, 1'b0, 1); drain();
    issue(2'b01, 5'd30, 5'd3,  32'h0,        32'h0000000F, 32'hC0000003, 1'b0, 1); drain();
    issue(2'b10, 5'd0,  5'd15, 32'hAAAA5555, 32'h1234ABCD, 32'hAAAAABCD, 1'b0, 1); drain();
    issue(2'b11, 5'd5,  5'd2,  32'hDEADBEEF, 32'h0F0F0F0F, 32'hDEADBEEF, 1'b1, 1); drain();
    issue(2'b10, 5'd31, 5'd0,  32'h12345678, 32'hFFFFFFFF, 32'h92345678, 1'b0, 1); drain();

    // Back-to-back with full-word masks: accepts must be 4 cycles apart.
    issue(2'b00, 5'd4, 5'd31, 32'h0, 32'h12345678, 32'h81234567, 1'b0, 1);
    gap_chk = 1;
    issue(2'b01, 5'd8, 5'd31, 32'h0, 32'h12345678, 32'h34567812, 1'b0, 1);
    drain();

    // Backpressure in DONE with a competing request that must be ignored.
    resp_ready = 1'b0;
    issue(2'b01, 5'd4, 5'd3, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFF5F, 1'b0, 1);
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_pos   = 5'd1;
    req_wm1   = 5'd1;
    req_a     = 32'h0;
    req_m     = 32'hFFFFFFFF;
    repeat (5) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_data",  resp_data,       32'hFFFFFF5F);
      chk("bp_req_ready",  32'(req_ready),  32'd0);
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 32'(req_ready),  32'd1);
    chk("bp_release_valid", 32'(resp_valid), 32'd0);
    drain();

    // Reset during MERGE discards the request.
    issue(2'b10, 5'd0, 5'd7, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rstm_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstm_req_ready",  32'(req_ready),  32'd1);
    reset_n = 1'b1;
    cnt_before = resp_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("rstm_no_resp", 32'(resp_cnt), 32'(cnt_before));

    issue(2'b00, 5'd16, 5'd7, 32'h0, 32'hA1B2C3D4, 32'h000000B2, 1'b0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_field_seq.md
BYTE_FIELD_SEQ -- requirements
Module: byte_field_seq

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low: ports clk (rising edge) and reset_n (sampled on clk; 0 = reset).
REQ-002 The ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  block can accept a request
- req_op  in  2  00 LDB, 01 DPB, 10 SDP (selective deposit), 11 reserved
- req_pos  in  5  field LSB position
- req_wm1  in  5  field width minus one
- req_a  in  32  destination word (DPB/SDP)
- req_m  in  32  source word
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  result word
- resp_err  out  1  reserved op flagged
REQ-003 The block SHALL have no parameters; the data width is fixed at 32 and the field controls at 5 bits.

Function
REQ-004 The FSM SHALL have states IDLE, LOOKUP, MERGE and DONE.
REQ-005 req_ready SHALL be 1 only in IDLE; a transfer occurs when req_valid & req_ready are high on a rising clk edge.
REQ-006 On transfer, the block SHALL register op, pos, wm1, a and m, drive the mask PROM addresses, and enter LOOKUP.
REQ-007 The left-mask PROM address SHALL be wm1 for LDB, and (pos+wm1) mod 32 otherwise.
REQ-008 The right-mask PROM address SHALL be 0 for LDB, and pos otherwise.
REQ-009 The PROMs SHALL be treated as registered, 1-cycle lookups; their outputs are valid in LOOKUP.
REQ-010 In LOOKUP the block SHALL form the mask. If op != LDB and pos+wm1 > 31 (6-bit sum, wrap), mask = L | R; otherwise mask = L & R. It SHALL then enter MERGE.
REQ-011 In MERGE the block SHALL register the result and enter DONE:
- LDB: rotr(m,pos) & mask
- DPB: (a & ~mask) | (rotl(m,pos) & mask)
- SDP: (a & ~mask) | (m & mask)
- reserved: a, with resp_err = 1
REQ-012 In DONE, resp_valid SHALL be 1 and resp_data/resp_err SHALL be held stable until resp_ready = 1; on that edge the FSM returns to IDLE.
REQ-013 Latency from the accept edge to resp_valid SHALL be exactly 3 cycles. Minimum request-to-request spacing SHALL be 4 cycles with resp_ready held high.
REQ-014 req_* inputs SHALL be ignored outside IDLE; captured operands SHALL not change until the next accept.
REQ-015 wm1 = 31 SHALL yield a full-word mask; LDB with wm1 = 31 returns rotr(m,pos).
REQ-016 resp_err SHALL be 0 for every defined op.

Reset
REQ-017 While reset_n = 0 at a clk edge, the FSM SHALL enter IDLE. resp_valid, resp_err and resp_data SHALL be 0, and req_ready SHALL be 1 on the first cycle after release.
REQ-018 Reset asserted in LOOKUP, MERGE or DONE SHALL discard the in-flight operation with no response produced.

Structure
REQ-019 A shared package SHALL hold the op encodings (LDB, DPB, SDP, reserved) and the FSM state encoding.
REQ-020 The block SHALL instantiate the existing left-mask and right-mask 32x32 PROM parts, one each.
REQ-021 One sub-module, rot32, SHALL be a combinational 32-bit rotator (data, 5-bit amount, direction); it SHALL be instantiated once and shared between LDB and DPB.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- LDB pos=8, wm1=7, m=0x12345678 -> resp_data=0x00000056, resp_valid 3 cycles after accept.
- DPB pos=4, wm1=3, a=0xFFFFFFFF, m=0x00000005 -> resp_data=0xFFFFFF5F.
- DPB wrap: pos=30, wm1=3, a=0, m=0xF -> mask=0xC0000003, resp_data=0xC0000003.
- SDP pos=0, wm1=15, a=0xAAAA5555, m=0x1234ABCD -> resp_data=0xAAAAABCD; reserved op with a=0xDEADBEEF -> resp_data=0xDEADBEEF, resp_err=1.
- Backpressure: resp_ready=0 for 5 cycles in DONE -> resp_data stable, req_ready=0, new req ignored; resp_ready=1 -> IDLE next cycle.
- reset_n low during MERGE -> next cycle resp_valid=0, req_ready=1, and no response is ever emitted for that request.
